// File: rtl/aes_pkg.sv
// +----------------------------------------------------------------------------+
// | aes_pkg : shared constants, types and GF(2^8) helper for the key schedule   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

package aes_pkg;

    localparam int         AES_NR    = 10;
    localparam logic [7:0] RCON_INIT = 8'h01;
    localparam logic [7:0] RCON_POLY = 8'h1B;

    typedef logic [31:0] word_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Multiply by x in GF(2^8), reduced by the AES polynomial
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
    endfunction

endpackage

`default_nettype wire

// File: rtl/aes_key_sched_if.sv
// +----------------------------------------------------------------------------+
// | aes_key_sched_if : key-in and round-key-out handshake bundle                |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

interface aes_key_sched_if;

    logic [127:0] key_in;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] rk_out;
    logic [3:0]   rk_idx;
    logic         rk_valid;
    logic         rk_ready;
    logic         rk_last;
    logic         replay;

    modport master (
        output key_in, key_valid, rk_ready, replay,
        input  key_ready, rk_out, rk_idx, rk_valid, rk_last
    );

    modport slave (
        input  key_in, key_valid, rk_ready, replay,
        output key_ready, rk_out, rk_idx, rk_valid, rk_last
    );

endinterface

`default_nettype wire

// File: rtl/aes_sbox.sv
// +----------------------------------------------------------------------------+
// | aes_sbox : combinational AES forward S-box (FIPS-197 SubBytes table)        |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module aes_sbox (
    input  wire logic [7:0] sbox_in_i,
    output logic      [7:0] sbox_out_o
);

    // Entry 0 occupies the most significant byte
    localparam logic [2047:0] c_SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [10:0] w_base;

    assign w_base     = 11'd2047 - {sbox_in_i, 3'b000};
    assign sbox_out_o = c_SBOX_TBL[w_base -: 8];

endmodule

`default_nettype wire

// File: rtl/aes_key_sched.sv
// +----------------------------------------------------------------------------+
// | aes_key_sched : iterative AES-128 key expansion, one round key per beat.    |
// | Optional AES_KEY_STORE_EN adds an 11-entry round-key store with replay.     |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module aes_key_sched
    import aes_pkg::*;
#(
    parameter int NK = 4,
    parameter int NR = AES_NR
) (
    input  wire logic       clk,
    input  wire logic       rst,
    aes_key_sched_if.slave  bus
);

    localparam int                 c_IDX_W    = $clog2(NR + 1);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NR);

    if (NK != 4) begin : g_nk_check
        $error("aes_key_sched supports only NK = 4 (AES-128)");
    end

    state_t               state_q, state_d;
    logic [127:0]         rk_q, rk_d;
    logic [c_IDX_W-1:0]   idx_q, idx_d;
    logic [7:0]           rcon_q, rcon_d;

    word_t                w_rot, w_sub, w_t;
    word_t                w_n0, w_n1, w_n2, w_n3;
    logic [127:0]         w_next_rk;
    logic                 w_final;

    // Next round key from the current working key
    assign w_rot = {rk_q[23:0], rk_q[31:24]};

    for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
        aes_sbox u_sbox (
            .sbox_in_i  (w_rot[8*gi +: 8]),
            .sbox_out_o (w_sub[8*gi +: 8])
        );
    end

    assign w_t       = w_sub ^ {rcon_q, 24'h0};
    assign w_n0      = rk_q[127:96] ^ w_t;
    assign w_n1      = rk_q[95:64]  ^ w_n0;
    assign w_n2      = rk_q[63:32]  ^ w_n1;
    assign w_n3      = rk_q[31:0]   ^ w_n2;
    assign w_next_rk = {w_n0, w_n1, w_n2, w_n3};
    assign w_final   = (idx_q == c_LAST_IDX);

`ifdef AES_KEY_STORE_EN
    logic [127:0] store_q [0:NR];
    logic         stored_q, stored_d;
    logic         replay_q, replay_d;

    always_ff @(posedge clk) begin
        if (state_q == EMIT && bus.rk_ready && !replay_q) begin
            store_q[idx_q] <= rk_q;
        end
    end

    assign bus.rk_out = replay_q ? store_q[idx_q] : rk_q;
`else
    logic w_unused_replay;

    assign w_unused_replay = bus.replay;
    assign bus.rk_out      = rk_q;
`endif

    always_comb begin
        state_d = state_q;
        rk_d    = rk_q;
        idx_d   = idx_q;
        rcon_d  = rcon_q;
`ifdef AES_KEY_STORE_EN
        stored_d = stored_q;
        replay_d = replay_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.key_valid) begin
                    state_d = EMIT;
                    rk_d    = bus.key_in;
                    idx_d   = '0;
                    rcon_d  = RCON_INIT;
`ifdef AES_KEY_STORE_EN
                    stored_d = 1'b0;
                    replay_d = 1'b0;
                end else if (bus.replay && stored_q) begin
                    state_d  = EMIT;
                    idx_d    = '0;
                    rcon_d   = RCON_INIT;
                    replay_d = 1'b1;
`endif
                end
            end
            EMIT: begin
                if (bus.rk_ready) begin
                    if (w_final) begin
                        state_d = IDLE;
`ifdef AES_KEY_STORE_EN
                        stored_d = 1'b1;
                        replay_d = 1'b0;
`endif
                    end else begin
                        idx_d  = idx_q + 1'b1;
                        rcon_d = xtime(rcon_q);
`ifdef AES_KEY_STORE_EN
                        // Working key is frozen during replay so it still holds key 10 afterwards
                        if (!replay_q) rk_d = w_next_rk;
`else
                        rk_d = w_next_rk;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rk_q    <= '0;
            idx_q   <= '0;
            rcon_q  <= RCON_INIT;
`ifdef AES_KEY_STORE_EN
            stored_q <= 1'b0;
            replay_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rk_q    <= rk_d;
            idx_q   <= idx_d;
            rcon_q  <= rcon_d;
`ifdef AES_KEY_STORE_EN
            stored_q <= stored_d;
            replay_q <= replay_d;
`endif
        end
    end

    assign bus.key_ready = (state_q == IDLE);
    assign bus.rk_valid  = (state_q == EMIT);
    assign bus.rk_last   = (state_q == EMIT) && w_final;
    assign bus.rk_idx    = idx_q;

endmodule

`default_nettype wire

// File: tb/tb_aes_key_sched.sv
// +----------------------------------------------------------------------------+
// | tb_aes_key_sched : self-checking bench for aes_key_sched (FIPS-197 model)   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_aes_key_sched;

    localparam logic [127:0] c_KEY_A  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] c_A_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] c_A_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] c_KEY_B  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] c_B_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    logic [7:0]   sb [0:255];
    logic [127:0] exp_rk [0:10];
    logic [127:0] obs_rk [0:10];

    aes_key_sched_if bus ();

    aes_key_sched dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box derived from GF(2^8) inverse plus affine transform
    task automatic build_sbox();
        for (int a = 0; a < 256; a++) begin
            logic [7:0] inv = 8'h00;
            for (int b = 1; b < 256; b++) begin
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            end
            sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // FIPS-197 KeyExpansion over 44 words
    task automatic build_model(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
                t = t ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic load_key(input logic [127:0] k);
        build_model(k);
        chk("load_key_ready", bus.key_ready, 1);
        bus.key_in    = k;
        bus.key_valid = 1'b1;
        @(negedge clk);
        bus.key_valid = 1'b0;
    endtask

    // Walks the 11 beats from the cycle after the load/replay handshake
    task automatic emit_check(input string nm, input int pct, input bit inject, input int rst_at);
        int beat = 0;
        int cyc  = 0;
        bit rdy;
        while (beat <= 10 && cyc < 400) begin
            if (rst_at >= 0 && beat == rst_at) begin
                rst = 1'b1;
                #1;
                chk({nm, "_rst_valid"}, bus.rk_valid, 0);
                chk({nm, "_rst_idx"},   bus.rk_idx, 0);
                chk({nm, "_rst_rk"},    bus.rk_out, 0);
                chk({nm, "_rst_last"},  bus.rk_last, 0);
                @(negedge clk);
                rst          = 1'b0;
                bus.rk_ready = 1'b0;
                return;
            end
            chk({nm, "_valid"}, bus.rk_valid, 1);
            chk({nm, "_idx"},   bus.rk_idx, 128'(beat));
            chk({nm, "_rk"},    bus.rk_out, exp_rk[beat]);
            chk({nm, "_last"},  bus.rk_last, 128'(beat == 10));
            obs_rk[beat] = bus.rk_out;
            if (inject) begin
                bus.key_valid = (beat >= 2 && beat <= 6);
                bus.key_in    = c_KEY_B;
                chk({nm, "_busy_ready"}, bus.key_ready, 0);
            end
            rdy = (pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < pct);
            bus.rk_ready = rdy;
            @(negedge clk);
            cyc++;
            if (rdy) beat++;
        end
        bus.key_valid = 1'b0;
        bus.rk_ready  = 1'b0;
        chk({nm, "_beats_done"}, 128'(beat), 11);
        if (pct >= 100) chk({nm, "_cycles"}, 128'(cyc), 11);
        chk({nm, "_end_valid"}, bus.rk_valid, 0);
        chk({nm, "_end_ready"}, bus.key_ready, 1);
    endtask

    initial begin
        tests         = 0;
        fails         = 0;
        rst           = 1'b1;
        bus.key_in    = '0;
        bus.key_valid = 1'b0;
        bus.rk_ready  = 1'b0;
        bus.replay    = 1'b0;
        build_sbox();

        repeat (3) @(negedge clk);
        chk("reset_valid", bus.rk_valid, 0);
        chk("reset_idx",   bus.rk_idx, 0);
        chk("reset_rk",    bus.rk_out, 0);
        chk("reset_last",  bus.rk_last, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_ready", bus.key_ready, 1);

        // Replay with nothing stored must be ignored
        bus.replay = 1'b1;
        @(negedge clk);
        bus.replay = 1'b0;
        chk("replay_empty_valid", bus.rk_valid, 0);
        @(negedge clk);
        chk("replay_empty_ready", bus.key_ready, 1);

        load_key(c_KEY_A);
        emit_check("a1", 100, 1'b0, -1);
        chk("a1_idx0",  obs_rk[0], c_KEY_A);
        chk("a1_idx1",  obs_rk[1], c_A_RK1);
        chk("a1_idx10", obs_rk[10], c_A_RK10);

`ifdef AES_KEY_STORE_EN
        bus.replay = 1'b1;
        @(negedge clk);
        bus.replay = 1'b0;
        emit_check("replay", 100, 1'b0, -1);
        chk("replay_idx10", obs_rk[10], c_A_RK10);
`else
        bus.replay = 1'b1;
        @(negedge clk);
        bus.replay = 1'b0;
        chk("replay_off_valid", bus.rk_valid, 0);
        chk("replay_off_ready", bus.key_ready, 1);
`endif

        load_key(c_KEY_A);
        emit_check("bp", 30, 1'b0, -1);
        chk("bp_idx10", obs_rk[10], c_A_RK10);

        load_key(c_KEY_A);
        emit_check("busy", 100, 1'b1, -1);
        chk("busy_idx10", obs_rk[10], c_A_RK10);
        load_key(c_KEY_B);
        emit_check("keyb", 100, 1'b0, -1);
        chk("keyb_idx10", obs_rk[10], c_B_RK10);

        load_key(c_KEY_A);
        emit_check("mid_rst", 100, 1'b0, 5);
        chk("mid_rst_ready", bus.key_ready, 1);
        chk("mid_rst_valid", bus.rk_valid, 0);
        bus.replay = 1'b1;
        @(negedge clk);
        bus.replay = 1'b0;
        chk("mid_rst_replay_valid", bus.rk_valid, 0);
        load_key(c_KEY_A);
        emit_check("fresh", 100, 1'b0, -1);
        chk("fresh_idx1", obs_rk[1], c_A_RK1);

        // Load and replay together: the load must win
        build_model(c_KEY_B);
        bus.key_in    = c_KEY_B;
        bus.key_valid = 1'b1;
        bus.replay    = 1'b1;
        @(negedge clk);
        bus.key_valid = 1'b0;
        bus.replay    = 1'b0;
        emit_check("both", 100, 1'b0, -1);
        chk("both_idx10", obs_rk[10], c_B_RK10);

        for (int n = 0; n < 3; n++) begin
            logic [127:0] rk;
            rk = {$urandom, $urandom, $urandom, $urandom};
            load_key(rk);
            emit_check("rand", 30 + 35 * n, 1'b0, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
